// File: rtl/vx_om_req_serializer.sv
// Serializes a multi-lane OM bus request into single-lane fragments, lowest
// active lane first, with back-to-back request acceptance on the last handoff.
module vx_om_req_serializer #(
   parameter int NUM_LANES  = 4,
   parameter int DIM_BITS   = 11,
   parameter int DEPTH_BITS = 24,
   parameter int UUID_WIDTH = 1,
   parameter int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [UUID_WIDTH-1:0]            req_uuid,
   input  logic [NUM_LANES-1:0]             req_mask,
   input  logic [NUM_LANES*DIM_BITS-1:0]    req_pos_x,
   input  logic [NUM_LANES*DIM_BITS-1:0]    req_pos_y,
   input  logic [NUM_LANES*32-1:0]          req_color,
   input  logic [NUM_LANES*DEPTH_BITS-1:0]  req_depth,
   input  logic [NUM_LANES-1:0]             req_face,
   output logic                             frag_valid,
   input  logic                             frag_ready,
   output logic [DIM_BITS-1:0]              frag_pos_x,
   output logic [DIM_BITS-1:0]              frag_pos_y,
   output logic [31:0]                      frag_color,
   output logic [DEPTH_BITS-1:0]            frag_depth,
   output logic                             frag_face,
   output logic [UUID_WIDTH-1:0]            frag_uuid,
   output logic [LANE_W-1:0]                frag_lane,
   output logic                             frag_last,
   output logic [31:0]                      frag_count
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                            state_q;
   logic [NUM_LANES-1:0]              rem_q;
   logic [NUM_LANES-1:0]              lane_oh;
   logic [LANE_W-1:0]                 lane_sel;
   logic                              fire;
   logic                              accept;

   logic [UUID_WIDTH-1:0]             uuid_q;
   logic [NUM_LANES*DIM_BITS-1:0]     pos_x_q;
   logic [NUM_LANES*DIM_BITS-1:0]     pos_y_q;
   logic [NUM_LANES*32-1:0]           color_q;
   logic [NUM_LANES*DEPTH_BITS-1:0]   depth_q;
   logic [NUM_LANES-1:0]              face_q;

   // Lowest set bit of the remaining mask picks the lane to present.
   always_comb begin
      lane_sel = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (rem_q[i]) lane_sel = LANE_W'(i);
      end
   end

   assign lane_oh    = rem_q & (~rem_q + NUM_LANES'(1));
   assign frag_valid = (state_q == BUSY);
   assign frag_last  = (|rem_q) && (rem_q == lane_oh);
   assign fire       = frag_valid && frag_ready;
   assign req_ready  = (state_q == IDLE) || (fire && frag_last);
   assign accept     = req_valid && req_ready;

   assign frag_lane  = lane_sel;
   assign frag_uuid  = uuid_q;
   assign frag_pos_x = pos_x_q[lane_sel*DIM_BITS +: DIM_BITS];
   assign frag_pos_y = pos_y_q[lane_sel*DIM_BITS +: DIM_BITS];
   assign frag_color = color_q[lane_sel*32 +: 32];
   assign frag_depth = depth_q[lane_sel*DEPTH_BITS +: DEPTH_BITS];
   assign frag_face  = face_q[lane_sel];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         frag_count <= '0;
      end else begin
         if (fire) frag_count <= frag_count + 32'd1;
         if (accept) begin
            // A zero-mask request is dropped without producing fragments.
            if (|req_mask) begin
               state_q <= BUSY;
               rem_q   <= req_mask;
            end else begin
               state_q <= IDLE;
               rem_q   <= '0;
            end
         end else if (fire) begin
            if (frag_last) begin
               state_q <= IDLE;
               rem_q   <= '0;
            end else begin
               rem_q   <= rem_q & ~lane_oh;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         uuid_q  <= req_uuid;
         pos_x_q <= req_pos_x;
         pos_y_q <= req_pos_y;
         color_q <= req_color;
         depth_q <= req_depth;
         face_q  <= req_face;
      end
   end

endmodule

// File: tb/tb_vx_om_req_serializer.sv
// Directed bench for vx_om_req_serializer: lane ordering, stalls, drops,
// back-to-back acceptance, mid-request reset and counter wrap.
module tb_vx_om_req_serializer;

   localparam int NL = 4;
   localparam int DB = 11;
   localparam int ZB = 24;
   localparam int UW = 1;
   localparam int LW = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [UW-1:0]    req_uuid = '0;
   logic [NL-1:0]    req_mask = '0;
   logic [NL*DB-1:0] req_pos_x = '0;
   logic [NL*DB-1:0] req_pos_y = '0;
   logic [NL*32-1:0] req_color = '0;
   logic [NL*ZB-1:0] req_depth = '0;
   logic [NL-1:0]    req_face = '0;
   logic             frag_valid;
   logic             frag_ready = 1'b0;
   logic [DB-1:0]    frag_pos_x;
   logic [DB-1:0]    frag_pos_y;
   logic [31:0]      frag_color;
   logic [ZB-1:0]    frag_depth;
   logic             frag_face;
   logic [UW-1:0]    frag_uuid;
   logic [LW-1:0]    frag_lane;
   logic             frag_last;
   logic [31:0]      frag_count;

   int total = 0;
   int bad = 0;

   vx_om_req_serializer #(
      .NUM_LANES(NL), .DIM_BITS(DB), .DEPTH_BITS(ZB), .UUID_WIDTH(UW)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid),
      .req_mask(req_mask), .req_pos_x(req_pos_x), .req_pos_y(req_pos_y),
      .req_color(req_color), .req_depth(req_depth), .req_face(req_face),
      .frag_valid(frag_valid), .frag_ready(frag_ready),
      .frag_pos_x(frag_pos_x), .frag_pos_y(frag_pos_y), .frag_color(frag_color),
      .frag_depth(frag_depth), .frag_face(frag_face), .frag_uuid(frag_uuid),
      .frag_lane(frag_lane), .frag_last(frag_last), .frag_count(frag_count)
   );

   always #5 clk = ~clk;

   // Lane l of a request built from base b carries x=b+l, y=b+50+l,
   // color=b*1000+l, depth=b*7+l, face=(b+l) odd.
   task automatic load_req(input logic [NL-1:0] m, input logic [UW-1:0] u, input int b);
      req_valid = 1'b1;
      req_mask  = m;
      req_uuid  = u;
      for (int i = 0; i < NL; i++) begin
         req_pos_x[i*DB +: DB] = DB'(b + i);
         req_pos_y[i*DB +: DB] = DB'(b + 50 + i);
         req_color[i*32 +: 32] = 32'(b * 1000 + i);
         req_depth[i*ZB +: ZB] = ZB'(b * 7 + i);
         req_face[i]           = ((b + i) % 2) == 1;
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      total++; if (frag_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", frag_valid); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
      total++; if (frag_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", frag_count); end
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int lanes [3] = '{0, 1, 3};
      @(negedge clk);
      load_req(4'b1011, 1'b1, 10);
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", req_ready); end
      @(negedge clk);
      req_valid = 1'b0;
      frag_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (frag_valid !== 1'b1) begin bad++; $display("FAIL basic_valid k=%0d got=%b want=1", k, frag_valid); end
         total++; if (frag_lane !== LW'(lanes[k])) begin bad++; $display("FAIL basic_lane k=%0d got=%0d want=%0d", k, frag_lane, lanes[k]); end
         total++; if (frag_last !== (k == 2)) begin bad++; $display("FAIL basic_last k=%0d got=%b want=%b", k, frag_last, k == 2); end
         total++; if (frag_pos_x !== DB'(10 + lanes[k]) || frag_pos_y !== DB'(60 + lanes[k])) begin
            bad++; $display("FAIL basic_pos k=%0d got=%0d,%0d want=%0d,%0d", k, frag_pos_x, frag_pos_y, 10 + lanes[k], 60 + lanes[k]); end
         total++; if (frag_color !== 32'(10000 + lanes[k]) || frag_depth !== ZB'(70 + lanes[k])) begin
            bad++; $display("FAIL basic_color_depth k=%0d got=%0d,%0d want=%0d,%0d", k, frag_color, frag_depth, 10000 + lanes[k], 70 + lanes[k]); end
         total++; if (frag_face !== (((10 + lanes[k]) % 2) == 1) || frag_uuid !== 1'b1) begin
            bad++; $display("FAIL basic_face_uuid k=%0d got=%b,%b", k, frag_face, frag_uuid); end
         @(negedge clk);
      end
      #1;
      total++; if (frag_valid !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", frag_valid); end
      total++; if (frag_count !== 32'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", frag_count); end
   endtask

   task automatic test_zero_mask();
      @(negedge clk);
      load_req(4'b0000, 1'b0, 20);
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b want=1", req_ready); end
      @(negedge clk);
      #1;
      total++; if (frag_valid !== 1'b0) begin bad++; $display("FAIL zero_valid got=%b want=0", frag_valid); end
      total++; if (frag_count !== 32'd3) begin bad++; $display("FAIL zero_count got=%0d want=3", frag_count); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL zero_ready2 got=%b want=1", req_ready); end
      load_req(4'b0001, 1'b0, 20);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      total++; if (frag_valid !== 1'b1 || frag_lane !== 2'd0 || frag_last !== 1'b1) begin
         bad++; $display("FAIL zero_next got=%b,%0d,%b want=1,0,1", frag_valid, frag_lane, frag_last); end
      @(negedge clk);
      #1;
      total++; if (frag_valid !== 1'b0 || frag_count !== 32'd4) begin
         bad++; $display("FAIL zero_next_done got=%b,%0d want=0,4", frag_valid, frag_count); end
   endtask

   task automatic test_stall();
      @(negedge clk);
      frag_ready = 1'b0;
      load_req(4'b0100, 1'b1, 30);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++; if (frag_valid !== 1'b1 || frag_lane !== 2'd2 || frag_last !== 1'b1) begin
            bad++; $display("FAIL stall_ctl k=%0d got=%b,%0d,%b want=1,2,1", k, frag_valid, frag_lane, frag_last); end
         total++; if (frag_pos_x !== DB'(32) || frag_color !== 32'd30002 || frag_depth !== ZB'(212)) begin
            bad++; $display("FAIL stall_data k=%0d got=%0d,%0d,%0d want=32,30002,212", k, frag_pos_x, frag_color, frag_depth); end
         total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready k=%0d got=%b want=0", k, req_ready); end
         @(negedge clk);
      end
      frag_ready = 1'b1;
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", req_ready); end
      @(negedge clk);
      #1;
      total++; if (frag_valid !== 1'b0 || frag_count !== 32'd5) begin
         bad++; $display("FAIL stall_done got=%b,%0d want=0,5", frag_valid, frag_count); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      frag_ready = 1'b1;
      load_req(4'b0011, 1'b0, 40);
      @(negedge clk);
      load_req(4'b1000, 1'b1, 60);
      #1;
      total++; if (frag_lane !== 2'd0 || frag_last !== 1'b0 || req_ready !== 1'b0 || frag_pos_x !== DB'(40)) begin
         bad++; $display("FAIL b2b_first got=%0d,%b,%b,%0d want=0,0,0,40", frag_lane, frag_last, req_ready, frag_pos_x); end
      @(negedge clk);
      #1;
      total++; if (frag_lane !== 2'd1 || frag_last !== 1'b1 || req_ready !== 1'b1 || frag_pos_x !== DB'(41)) begin
         bad++; $display("FAIL b2b_second got=%0d,%b,%b,%0d want=1,1,1,41", frag_lane, frag_last, req_ready, frag_pos_x); end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      total++; if (frag_valid !== 1'b1 || frag_lane !== 2'd3 || frag_last !== 1'b1 || frag_pos_x !== DB'(63) || frag_uuid !== 1'b1) begin
         bad++; $display("FAIL b2b_third got=%b,%0d,%b,%0d,%b want=1,3,1,63,1", frag_valid, frag_lane, frag_last, frag_pos_x, frag_uuid); end
      @(negedge clk);
      #1;
      total++; if (frag_valid !== 1'b0 || frag_count !== 32'd8) begin
         bad++; $display("FAIL b2b_done got=%b,%0d want=0,8", frag_valid, frag_count); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      frag_ready = 1'b1;
      load_req(4'b1111, 1'b0, 70);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      total++; if (frag_valid !== 1'b1 || frag_lane !== 2'd0) begin
         bad++; $display("FAIL rmid_first got=%b,%0d want=1,0", frag_valid, frag_lane); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (frag_valid !== 1'b0 || frag_count !== 32'd0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL rmid_reset got=%b,%0d,%b want=0,0,1", frag_valid, frag_count, req_ready); end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         total++; if (frag_valid !== 1'b0) begin bad++; $display("FAIL rmid_after k=%0d got=%b want=0", k, frag_valid); end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.frag_count = 32'hFFFF_FFFF;
      #1;
      release dut.frag_count;
      #1;
      total++; if (frag_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preset got=%h want=ffffffff", frag_count); end
      frag_ready = 1'b1;
      load_req(4'b0110, 1'b0, 80);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      total++; if (frag_lane !== 2'd1 || frag_count !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL wrap_first got=%0d,%h want=1,ffffffff", frag_lane, frag_count); end
      @(negedge clk);
      #1;
      total++; if (frag_lane !== 2'd2 || frag_count !== 32'd0) begin
         bad++; $display("FAIL wrap_zero got=%0d,%0d want=2,0", frag_lane, frag_count); end
      @(negedge clk);
      #1;
      total++; if (frag_valid !== 1'b0 || frag_count !== 32'd1) begin
         bad++; $display("FAIL wrap_final got=%b,%0d want=0,1", frag_valid, frag_count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_mask();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vx_om_req_serializer.md
VX_OM_REQ_SERIALIZER -- requirements
Module: VX_om_req_serializer

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 4, the lane count of the incoming OM bus request.
REQ-002 The block SHALL have parameter DIM_BITS, default 11, the width of pos_x and pos_y per lane.
REQ-003 The block SHALL have parameter DEPTH_BITS, default 24, the width of depth per lane.
REQ-004 The block SHALL have parameter UUID_WIDTH, default 1, the width of the request uuid.
REQ-005 The block SHALL have clk, input, 1, the single clock; all state is on its rising edge.
REQ-006 The block SHALL have reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have req_valid, input, 1, OM bus request valid from a core agent.
REQ-008 The block SHALL have req_ready, output, 1, request accepted when req_valid && req_ready at a clock edge.
REQ-009 The block SHALL have req_uuid, input, UUID_WIDTH, request tag.
REQ-010 The block SHALL have req_mask, input, NUM_LANES, active-lane mask.
REQ-011 The block SHALL have req_pos_x and req_pos_y, input, NUM_LANES*DIM_BITS each, per-lane pixel coordinates, lane i at bits [i*DIM_BITS +: DIM_BITS].
REQ-012 The block SHALL have req_color, input, NUM_LANES*32, per-lane color.
REQ-013 The block SHALL have req_depth, input, NUM_LANES*DEPTH_BITS, per-lane depth.
REQ-014 The block SHALL have req_face, input, NUM_LANES, per-lane face bit.
REQ-015 The block SHALL have frag_valid, output, 1, fragment valid toward the OM pipeline.
REQ-016 The block SHALL have frag_ready, input, 1, fragment consumed when frag_valid && frag_ready.
REQ-017 The block SHALL have frag_pos_x, frag_pos_y, frag_color, frag_depth, frag_face and frag_uuid, outputs, single-lane widths, the fragment payload.
REQ-018 The block SHALL have frag_lane, output, max(1, clog2(NUM_LANES)), the source lane index.
REQ-019 The block SHALL have frag_last, output, 1, high on the final fragment of a request.
REQ-020 The block SHALL have frag_count, output, 32, the count of fragments handed off.

Function
REQ-021 The block SHALL use states IDLE and BUSY, with a registered request payload and a registered remaining-mask rem.
REQ-022 In IDLE, the block SHALL drive req_ready=1 and frag_valid=0.
REQ-023 When a request with nonzero mask is accepted in IDLE, the block SHALL capture the payload, set rem=req_mask and go to BUSY, so the first fragment is valid the next cycle (1-cycle latency).
REQ-024 When a request with mask==0 is accepted, the block SHALL drop it, emit no fragment and stay in IDLE.
REQ-025 In BUSY, frag_valid SHALL be 1, the block SHALL present the lowest-index set bit of rem (the lane), and its outputs SHALL select that lane's fields.
REQ-026 frag_last SHALL equal 1 exactly when rem has a single bit set.
REQ-027 On a fragment handshake with frag_last=0, the block SHALL clear that lane's bit in rem.
REQ-028 On a fragment handshake with frag_last=1, the block SHALL return to IDLE, unless a new request is accepted in the same cycle.
REQ-029 In BUSY, req_ready SHALL be frag_valid && frag_ready && frag_last, so a new request can be accepted back-to-back on the last handoff, with no bubble.
REQ-030 A back-to-back request with a nonzero mask SHALL load BUSY directly; one with a zero mask SHALL go to IDLE.
REQ-031 While frag_valid=1 && frag_ready=0, all frag_* outputs SHALL hold stable.
REQ-032 frag_count SHALL increment by 1 on each fragment handshake and wrap from 0xFFFFFFFF to 0.
REQ-033 Nothing SHALL be inferred from req_* fields of lanes not set in req_mask.

Reset
REQ-034 On reset assertion, the block SHALL asynchronously set state=IDLE, rem=0, frag_count=0, frag_valid=0 and req_ready=1.
REQ-035 Payload registers SHALL need no reset.
REQ-036 Reset asserted mid-request SHALL discard all pending fragments, and no fragment of that request SHALL appear after reset deasserts.

Verification
REQ-037 Mask 4'b1011, frag_ready=1 -> fragments for lanes 0, 1 and 3 on 3 consecutive cycles, frag_last only on lane 3, frag_count=3.
REQ-038 Mask 4'b0000 -> req_ready=1, no frag_valid, frag_count unchanged, next request accepted the following cycle.
REQ-039 Mask 4'b0100 with frag_ready held 0 for 5 cycles -> lane 2 fields and frag_last=1 stay stable, req_ready=0; frag_ready=1 -> handoff, then IDLE.
REQ-040 Two requests, 4'b0011 then 4'b1000, with req_valid held -> second accepted on the cycle lane 1 is handed off, lane 3 fragment next cycle, no bubble.
REQ-041 Reset asserted after the first of 4 fragments (mask 4'b1111) -> frag_valid=0 immediately, frag_count=0, no remaining fragments after release.
REQ-042 frag_count forced near wrap (0xFFFFFFFF) plus 2 fragments -> frag_count=1.
